// File: rtl/lock_key_pkg.sv
// Shared widths, CRC polynomial and FSM states for the lock key loader.
// Imported by the loader top and its serial CRC engine.
package lock_key_pkg;

    localparam int KEY_W = 92;
    localparam int CRC_W = 8;
    localparam int CNT_W = 7;
    localparam logic [7:0] CRC_POLY = 8'h07;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        CHECK
    } state_t;

endpackage

// File: rtl/lock_key_loader_if.sv
// Serial key-bit handshake between a key source and the loader.
// The master drives bits; the slave signals when it can take one.
interface lock_key_loader_if;

    logic key_bit;
    logic key_valid;
    logic key_ready;

    modport master (
        output key_bit,
        output key_valid,
        input  key_ready
    );

    modport slave (
        input  key_bit,
        input  key_valid,
        output key_ready
    );

endinterface

// File: rtl/crc8_serial.sv
// Bit-serial CRC-8 (poly 0x07, init 0, no reflection, no final XOR).
// One message bit per enabled cycle; clr returns it to the init value.
module crc8_serial
    import lock_key_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       en,
    input  logic       in_bit,
    output logic [7:0] crc
);

    logic [7:0] r_crc;
    logic       w_fb;

    assign w_fb = r_crc[7] ^ in_bit;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_crc <= 8'h00;
        end else if (en) begin
            r_crc <= {r_crc[6:0], 1'b0} ^ (w_fb ? CRC_POLY : 8'h00);
        end
    end

    assign crc = r_crc;

endmodule

// File: rtl/lock_key_loader.sv
// Loads a logic-locking key serially, verifies its CRC-8 and commits it
// to key_out only on a match; the previous key stays live meanwhile.
module lock_key_loader
    import lock_key_pkg::*;
#(
    parameter int KEY_W = lock_key_pkg::KEY_W,
    parameter int CRC_W = lock_key_pkg::CRC_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             zeroize,
    lock_key_loader_if.slave bus,
    output logic [KEY_W-1:0] key_out,
    output logic             key_ok,
    output logic             done,
    output logic             err
);

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(KEY_W + CRC_W - 1);
    localparam logic [CNT_W-1:0] KEY_CNT  = CNT_W'(KEY_W);

    state_t             r_state;
    state_t             w_next;
    logic [CNT_W-1:0]   r_cnt;
    logic [KEY_W-1:0]   r_shadow;
    logic [CRC_W-1:0]   r_rx;
    logic [KEY_W-1:0]   r_key;
    logic               r_key_ok;
    logic [7:0]         w_crc;
    logic               w_ready;
    logic               w_acc;
    logic               w_clr;
    logic               w_in_key;
    logic               w_match;
    logic               w_done;
    logic               w_err;

    // An abort or zeroize in the same cycle wins over taking the bit.
    assign w_acc    = bus.key_valid && (r_state == LOAD) && !start && !zeroize;
    assign w_clr    = zeroize || (start && (r_state != CHECK));
    assign w_in_key = (r_cnt < KEY_CNT);
    assign w_match  = (r_rx == w_crc);

    crc8_serial u_crc (
        .clk    (clk),
        .rst    (rst),
        .clr    (w_clr),
        .en     (w_acc && w_in_key),
        .in_bit (bus.key_bit),
        .crc    (w_crc)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next  = r_state;
        w_ready = 1'b0;
        w_done  = 1'b0;
        w_err   = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (start) w_next = LOAD;
            end
            LOAD: begin
                w_ready = 1'b1;
                if (start) begin
                    w_next = LOAD;
                end else if (w_acc && (r_cnt == LAST_IDX)) begin
                    w_next = CHECK;
                end
            end
            CHECK: begin
                w_next = IDLE;
                w_done = w_match;
                w_err  = !w_match;
            end
            default: w_next = IDLE;
        endcase
        if (zeroize) begin
            w_next = IDLE;
            w_done = 1'b0;
            w_err  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt    <= '0;
            r_shadow <= '0;
            r_rx     <= '0;
            r_key    <= '0;
            r_key_ok <= 1'b0;
        end else begin
            if (w_clr) begin
                r_cnt    <= '0;
                r_shadow <= '0;
                r_rx     <= '0;
            end else if (w_acc) begin
                r_cnt <= r_cnt + CNT_W'(1);
                // Bit 0 arrives first, so shifting down lands it at [0].
                if (w_in_key) begin
                    r_shadow <= {bus.key_bit, r_shadow[KEY_W-1:1]};
                end else begin
                    r_rx <= {r_rx[CRC_W-2:0], bus.key_bit};
                end
            end
            if (zeroize) begin
                r_key    <= '0;
                r_key_ok <= 1'b0;
            end else if (w_done) begin
                r_key    <= r_shadow;
                r_key_ok <= 1'b1;
            end
        end
    end

    assign bus.key_ready = w_ready;
    assign key_out       = r_key;
    assign key_ok        = r_key_ok;
    assign done          = w_done;
    assign err           = w_err;

endmodule

// File: doc/lock_key_loader.md
LOCK_KEY_LOADER -- requirements
Module: lock_key_loader

Interface
REQ-001 SHALL have parameter KEY_W, default 92, meaning key width: bits 0..87 = X_1..X_88, bits 88..91 = p1..p4.
REQ-002 SHALL have parameter CRC_W, default 8, meaning frame check width.
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port rst  input  1  synchronous active-high reset.
REQ-005 SHALL have port start  input  1  single-cycle pulse opening a new load frame.
REQ-006 SHALL have port zeroize  input  1  clears the committed key.
REQ-007 SHALL have port key_bit  input  1  serial frame data.
REQ-008 SHALL have port key_valid  input  1  key_bit qualifier.
REQ-009 SHALL have port key_ready  output  1  loader accepts a bit this cycle.
REQ-010 SHALL have port key_out  output  KEY_W  committed key driving the locked netlist's X_n/p_n inputs.
REQ-011 SHALL have port key_ok  output  1  key_out holds a CRC-verified key.
REQ-012 SHALL have port done  output  1  one-cycle pulse, frame accepted.
REQ-013 SHALL have port err  output  1  one-cycle pulse, frame rejected.

Function
REQ-014 SHALL implement states IDLE, LOAD, CHECK; IDLE->LOAD on start; LOAD->CHECK when bit KEY_W+CRC_W-1 is accepted; CHECK->IDLE unconditionally after one cycle.
REQ-015 SHALL assert key_ready only in LOAD; a bit SHALL be accepted only when key_valid && key_ready.
REQ-016 SHALL receive frame = KEY_W key bits (bit 0 first) then CRC_W check bits (MSB first), counted by a 7-bit counter cleared on start.
REQ-017 SHALL compute CRC-8, poly 0x07, init 0x00, no reflection, no final XOR, over the KEY_W key bits in arrival order: crc <= {crc[6:0],1'b0} ^ ((crc[7]^bit) ? 8'h07 : 8'h00).
REQ-018 SHALL assemble key bits in a shadow register; key_out SHALL never change during LOAD.
REQ-019 In CHECK, on CRC match: key_out <= shadow, key_ok <= 1, done = 1 for that cycle.
REQ-020 In CHECK, on mismatch: key_out and key_ok unchanged, err = 1 for that cycle.
REQ-021 Latency: done/err SHALL assert exactly one cycle after the cycle accepting the last check bit.
REQ-022 start while in LOAD SHALL abort the frame, clear counter/shadow/CRC and restart LOAD next cycle; no done/err produced.
REQ-023 start while in CHECK SHALL be ignored.
REQ-024 key_valid outside LOAD SHALL be ignored; gaps (key_valid low) in LOAD SHALL stall without timeout.
REQ-025 zeroize SHALL clear key_out to 0 and key_ok to 0 next cycle, and return FSM to IDLE; zeroize has priority over start and over a CHECK commit in the same cycle.
REQ-026 key_ok SHALL remain high through a subsequent LOAD until zeroize, reset or a commit (old key stays active).

Reset
REQ-027 On rst: state IDLE, key_out 0, key_ok 0, key_ready 0, done 0, err 0, counter/shadow/CRC 0; rst mid-frame SHALL discard the frame silently.
REQ-028 rst SHALL take priority over all other inputs.

Structure
REQ-029 SHALL place KEY_W, CRC_W, CRC poly 0x07 and the state enumeration in shared package lock_key_pkg.
REQ-030 SHALL isolate the bit-serial CRC update in sub-module crc8_serial (inputs clk, rst, clr, en, bit; output crc[7:0]).

Verification
REQ-031 Reset, then 92 zero key bits + CRC 0x00 -> done pulse 1 cycle after last bit, key_ok=1, key_out=0.
REQ-032 Key with only bit 0 (X_1) = 1, CRC from reference model -> done, key_out=92'h1; same key with CRC bit 0 inverted -> err, key_out stays 92'h1.
REQ-033 Valid frame with key_valid toggled 1-0-1 every cycle -> identical key_out/done as back-to-back frame, ~2x duration.
REQ-034 start asserted after 40 bits, then full valid frame of all-ones key -> single done, key_out=all ones, no err.
REQ-035 zeroize in same cycle as CHECK of a valid frame -> key_out=0, key_ok=0, no done.
REQ-036 rst after 50 bits, then valid frame -> only the second frame commits; no pulse from the first.
